// File: rtl/puf_pkg.sv
// puf_pkg: shared state encoding and widths for the PUF frame controller.
package puf_pkg;
  localparam int BYTE_W = 8;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {ST_RX, ST_CHAL, ST_WAIT, ST_TX} state_e;
endpackage

// File: rtl/puf_byte_shifter.sv
// puf_byte_shifter: byte-granular register with parallel load, byte shift and byte insert.
module puf_byte_shifter import puf_pkg::*; #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [N*BYTE_W-1:0] load_data_i,
  input  logic                shift_i,
  input  logic                insert_i,
  input  logic [IW-1:0]       idx_i,
  input  logic [BYTE_W-1:0]   byte_i,
  output logic [N*BYTE_W-1:0] data_o,
  output logic [BYTE_W-1:0]   head_o
);
  localparam int W = N * BYTE_W;
  logic [W-1:0] data_q, data_d, ins_data, shf_data;
  always_comb begin
    ins_data = data_q;
    if (MSB_FIRST) ins_data = (data_q << BYTE_W) | W'(byte_i);
    else for (int i = 0; i < N; i++) if (idx_i == IW'(i)) ins_data[i*BYTE_W +: BYTE_W] = byte_i;
    shf_data = MSB_FIRST ? data_q << BYTE_W : data_q >> BYTE_W;
    data_d = load_i ? load_data_i : insert_i ? ins_data : shift_i ? shf_data : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  end
  assign data_o = data_q;
  assign head_o = MSB_FIRST ? data_q[W-1 -: BYTE_W] : data_q[BYTE_W-1:0];
endmodule

// File: rtl/puf_frame_ctrl.sv
// puf_frame_ctrl: assembles UART bytes into a PUF challenge and serialises the response back.
module puf_frame_ctrl import puf_pkg::*; #(
  parameter int CHAL_BYTES = 8,
  parameter int RESP_BYTES = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [BYTE_W-1:0]            rx_byte,
  output logic                         tx_valid,
  output logic [BYTE_W-1:0]            tx_byte,
  input  logic                         tx_ready,
  output logic                         chal_valid,
  output logic [CHAL_BYTES*BYTE_W-1:0] chal_data,
  input  logic                         chal_ready,
  input  logic                         resp_valid,
  input  logic [RESP_BYTES*BYTE_W-1:0] resp_data,
  output logic                         resp_ready,
  output logic                         busy,
  output logic [DROP_W-1:0]            drop_count
);
  localparam int CW = $clog2(CHAL_BYTES + 1);
  localparam int RW = $clog2(RESP_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [RW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic rx_prev_q, rx_edge, rx_ins, rx_clr, tx_load, tx_shift, drop_inc;
  logic [BYTE_W-1:0] rx_head;
  logic [RESP_BYTES*BYTE_W-1:0] tx_data;
  logic unused_bits;
  // rx_prev_q resets low so an rx_valid stuck high out of reset counts as one edge
  assign rx_edge = rx_valid && !rx_prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RX;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      idle_q    <= '0;
      drop_q    <= '0;
      rx_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      idle_q    <= idle_d;
      drop_q    <= drop_d;
      rx_prev_q <= rx_valid;
    end
  end
  always_comb begin
    state_d = state_q;
    in_cnt_d = in_cnt_q;
    out_cnt_d = out_cnt_q;
    idle_d = idle_q;
    rx_ins = 1'b0;
    rx_clr = 1'b0;
    tx_load = 1'b0;
    tx_shift = 1'b0;
    drop_inc = rx_edge && state_q != ST_RX;
    case (state_q)
      ST_RX: begin
        if (rx_edge) begin
          rx_ins = 1'b1;
          idle_d = '0;
          in_cnt_d = in_cnt_q == CW'(CHAL_BYTES - 1) ? '0 : in_cnt_q + 1'b1;
          state_d = in_cnt_q == CW'(CHAL_BYTES - 1) ? ST_CHAL : ST_RX;
        end else if (in_cnt_q != '0) begin
          // an arriving byte takes priority over expiry, so it is handled above
          if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
            idle_d = '0;
            in_cnt_d = '0;
            rx_clr = 1'b1;
            drop_inc = 1'b1;
          end else idle_d = idle_q + 1'b1;
        end
      end
      ST_CHAL: state_d = chal_ready ? ST_WAIT : ST_CHAL;
      ST_WAIT: begin
        tx_load = resp_valid;
        out_cnt_d = resp_valid ? '0 : out_cnt_q;
        state_d = resp_valid ? ST_TX : ST_WAIT;
      end
      default: begin
        tx_shift = tx_ready;
        out_cnt_d = tx_ready ? out_cnt_q + 1'b1 : out_cnt_q;
        state_d = tx_ready && out_cnt_q == RW'(RESP_BYTES - 1) ? ST_RX : ST_TX;
      end
    endcase
    drop_d = drop_inc && drop_q != '1 ? drop_q + 1'b1 : drop_q;
  end
  puf_byte_shifter #(.N(CHAL_BYTES), .MSB_FIRST(MSB_FIRST), .IW(CW)) u_rx (
    .clk(clk), .rst_n(rst_n), .load_i(rx_clr), .load_data_i('0), .shift_i(1'b0),
    .insert_i(rx_ins), .idx_i(in_cnt_q), .byte_i(rx_byte), .data_o(chal_data), .head_o(rx_head)
  );
  puf_byte_shifter #(.N(RESP_BYTES), .MSB_FIRST(MSB_FIRST), .IW(RW)) u_tx (
    .clk(clk), .rst_n(rst_n), .load_i(tx_load), .load_data_i(resp_data), .shift_i(tx_shift),
    .insert_i(1'b0), .idx_i('0), .byte_i('0), .data_o(tx_data), .head_o(tx_byte)
  );
  assign chal_valid = state_q == ST_CHAL;
  assign resp_ready = state_q == ST_WAIT;
  assign tx_valid = state_q == ST_TX;
  assign busy = state_q != ST_RX;
  assign drop_count = drop_q;
  assign unused_bits = ^{rx_head, tx_data};
endmodule

// File: tb/tb_puf_frame_ctrl.sv
// tb_puf_frame_ctrl: scoreboard bench over an 8-byte MSB-first and a 4/2-byte LSB-first instance.
module tb_puf_frame_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic rx_valid0 = 1'b0, tx_valid0, tx_ready0 = 1'b1, chal_valid0, chal_ready0 = 1'b0;
  logic resp_valid0 = 1'b0, resp_ready0, busy0;
  logic [7:0] rx_byte0 = '0, tx_byte0, drop0;
  logic [63:0] chal_data0, resp_data0 = '0;
  logic rx_valid1 = 1'b0, tx_valid1, tx_ready1 = 1'b1, chal_valid1, chal_ready1 = 1'b0;
  logic resp_valid1 = 1'b0, resp_ready1, busy1;
  logic [7:0] rx_byte1 = '0, tx_byte1, drop1;
  logic [31:0] chal_data1;
  logic [15:0] resp_data1 = '0;
  int checks = 0, errors = 0;
  bit rnd0 = 1'b0;
  logic [7:0] txq0[$], txq1[$];
  logic [63:0] chalq0[$], chalq1[$];

  puf_frame_ctrl #(.CHAL_BYTES(8), .RESP_BYTES(8), .TIMEOUT_CYCLES(100), .MSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid0), .rx_byte(rx_byte0), .tx_valid(tx_valid0),
    .tx_byte(tx_byte0), .tx_ready(tx_ready0), .chal_valid(chal_valid0), .chal_data(chal_data0),
    .chal_ready(chal_ready0), .resp_valid(resp_valid0), .resp_data(resp_data0),
    .resp_ready(resp_ready0), .busy(busy0), .drop_count(drop0)
  );
  puf_frame_ctrl #(.CHAL_BYTES(4), .RESP_BYTES(2), .TIMEOUT_CYCLES(20), .MSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid1), .rx_byte(rx_byte1), .tx_valid(tx_valid1),
    .tx_byte(tx_byte1), .tx_ready(tx_ready1), .chal_valid(chal_valid1), .chal_data(chal_data1),
    .chal_ready(chal_ready1), .resp_valid(resp_valid1), .resp_data(resp_data1),
    .resp_ready(resp_ready1), .busy(busy1), .drop_count(drop1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    tx_ready0 = rnd0 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // scoreboard pops plus valid/payload hold checks while a handshake is pending
  logic hold0 = 1'b0, hold1 = 1'b0, chold0 = 1'b0;
  logic [7:0] held0 = '0, held1 = '0;
  logic [63:0] cheld0 = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold0 = 1'b0;
      chold0 = 1'b0;
    end else begin
      if (hold0) begin
        check("tx0_keep", tx_valid0, 1);
        check("tx0_stable", tx_byte0, held0);
      end
      if (chold0) begin
        check("chal0_keep", chal_valid0, 1);
        check("chal0_stable", chal_data0, cheld0);
      end
      if (tx_valid0 && tx_ready0) begin
        if (txq0.size() == 0) check("tx0_extra", 64'(txq0.size()), 1);
        else check("tx0_byte", tx_byte0, txq0.pop_front());
      end
      if (chal_valid0 && chal_ready0) begin
        if (chalq0.size() == 0) check("chal0_extra", 64'(chalq0.size()), 1);
        else check("chal0_data", chal_data0, chalq0.pop_front());
      end
      hold0 = tx_valid0 && !tx_ready0;
      held0 = tx_byte0;
      chold0 = chal_valid0 && !chal_ready0;
      cheld0 = chal_data0;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) hold1 = 1'b0;
    else begin
      if (hold1) check("tx1_stable", tx_byte1, held1);
      if (tx_valid1 && tx_ready1) begin
        if (txq1.size() == 0) check("tx1_extra", 64'(txq1.size()), 1);
        else check("tx1_byte", tx_byte1, txq1.pop_front());
      end
      if (chal_valid1 && chal_ready1) begin
        if (chalq1.size() == 0) check("chal1_extra", 64'(chalq1.size()), 1);
        else check("chal1_data", 64'(chal_data1), chalq1.pop_front());
      end
      hold1 = tx_valid1 && !tx_ready1;
      held1 = tx_byte1;
    end
  end

  task automatic send(input int d, input logic [7:0] b);
    @(posedge clk); #1;
    if (d == 0) begin rx_valid0 = 1'b1; rx_byte0 = b; end
    else begin rx_valid1 = 1'b1; rx_byte1 = b; end
    repeat (2) @(posedge clk);
    #1;
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while ((d == 0 ? busy0 : busy1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", d == 0 ? busy0 : busy1, 0);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_chal_valid"}, chal_valid0, 0);
    check({tag, "_resp_ready"}, resp_ready0, 0);
    check({tag, "_tx_valid"}, tx_valid0, 0);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_drop"}, drop0, 0);
    check({tag, "_chal_data"}, chal_data0, 0);
    check({tag, "_tx_byte"}, tx_byte0, 0);
  endtask

  task automatic frame0(input logic [7:0] cbase, input logic [7:0] rbase);
    logic [63:0] c, r;
    for (int i = 0; i < 8; i++) begin
      c = {c[55:0], 8'(cbase + 8'(i))};
      r = {r[55:0], 8'(rbase + 8'(i))};
      txq0.push_back(8'(rbase + 8'(i)));
    end
    chalq0.push_back(c);
    resp_data0 = r;
    for (int i = 0; i < 8; i++) send(0, 8'(cbase + 8'(i)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset0("rst");
    check("rst_busy1", busy1, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset0("post_rst");
    // MSB-first frame with exact handshake latencies
    chal_ready0 = 1'b1;
    resp_valid0 = 1'b1;
    resp_data0 = 64'hA1A2A3A4A5A6A7A8;
    chalq0.push_back(64'h0102030405060708);
    for (int i = 0; i < 8; i++) txq0.push_back(8'(8'hA1 + 8'(i)));
    for (int i = 1; i <= 7; i++) send(0, 8'(i));
    @(posedge clk); #1;
    rx_valid0 = 1'b1;
    rx_byte0 = 8'h08;
    @(negedge clk); check("chal_pre", chal_valid0, 0);
    @(negedge clk); check("chal_lat", chal_valid0, 1);
    check("chal_val", chal_data0, 64'h0102030405060708);
    @(negedge clk); check("resp_lat", resp_ready0, 1);
    @(negedge clk); check("tx_lat", tx_valid0, 1);
    check("tx_first", tx_byte0, 8'hA1);
    @(posedge clk); #1 rx_valid0 = 1'b0;
    wait_idle(0);
    check("t1_drop", drop0, 0);
    // partial frame timeout, boundary just before and after expiry
    for (int i = 0; i < 3; i++) send(0, 8'(8'h50 + 8'(i)));
    repeat (95) @(negedge clk);
    check("to_early", drop0, 0);
    repeat (15) @(negedge clk);
    check("to_drop", drop0, 1);
    check("to_busy", busy0, 0);
    // new frame held in CHAL while extra bytes arrive
    chal_ready0 = 1'b0;
    resp_valid0 = 1'b0;
    chalq0.push_back(64'h1011121314151617);
    for (int i = 0; i < 8; i++) send(0, 8'(8'h10 + 8'(i)));
    @(negedge clk); check("hold_valid", chal_valid0, 1);
    send(0, 8'hAA);
    send(0, 8'hBB);
    repeat (50) @(negedge clk);
    check("hold_drop", drop0, 3);
    check("hold_valid2", chal_valid0, 1);
    check("hold_data", chal_data0, 64'h1011121314151617);
    resp_data0 = 64'hC0C1C2C3C4C5C6C7;
    for (int i = 0; i < 8; i++) txq0.push_back(8'(8'hC0 + 8'(i)));
    rnd0 = 1'b1;
    @(posedge clk); #1 chal_ready0 = 1'b1;
    repeat (5) @(negedge clk);
    check("wait_rdy", resp_ready0, 1);
    check("wait_txv", tx_valid0, 0);
    @(posedge clk); #1 resp_valid0 = 1'b1;
    wait_idle(0);
    rnd0 = 1'b0;
    // reset after three transmitted bytes, then a clean frame
    frame0(8'h20, 8'hD0);
    n = 0;
    while (txq0.size() > 5 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("pre_rst_q", 64'(txq0.size()), 5);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset0("mid_rst");
    txq0.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame0(8'h30, 8'hE0);
    wait_idle(0);
    check("final_chal", chal_data0, 64'h3031323334353637);
    // LSB-first instance, then drop counter saturation
    chal_ready1 = 1'b1;
    resp_valid1 = 1'b1;
    resp_data1 = 16'hBEEF;
    chalq1.push_back(64'h44332211);
    txq1.push_back(8'hEF);
    txq1.push_back(8'hBE);
    send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
    wait_idle(1);
    check("d1_chal", 64'(chal_data1), 64'h44332211);
    check("d1_drop", drop1, 0);
    chal_ready1 = 1'b0;
    chalq1.push_back(64'h04030201);
    for (int i = 1; i <= 4; i++) send(1, 8'(i));
    for (int i = 0; i < 260; i++) send(1, 8'hFF);
    check("d1_sat", drop1, 8'd255);
    check("d1_hold", 64'(chal_data1), 64'h04030201);
    txq1.push_back(8'hEF);
    txq1.push_back(8'hBE);
    @(posedge clk); #1 chal_ready1 = 1'b1;
    wait_idle(1);
    check("d1_sat_keep", drop1, 8'd255);
    check("txq0_empty", 64'(txq0.size()), 0);
    check("txq1_empty", 64'(txq1.size()), 0);
    check("chalq0_empty", 64'(chalq0.size()), 0);
    check("chalq1_empty", 64'(chalq1.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
